// File: rtl/rxuart_lite.sv
// rxuart_lite: 8N1 UART receiver with 2-flop synchroniser and mid-baud sampling.
// Define RXUART_PARITY_EN for 8E1 frames with an extra o_parity_err output.
module rxuart_lite #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
`ifdef RXUART_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_frame_err
);

  localparam logic [23:0] HALF_C = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_C = CLOCKS_PER_BAUD - 24'd1;

`ifdef RXUART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_err_f(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t      state_r, state_s;
  logic        rx_meta_r, ck_rx_r;
  logic [23:0] cnt_r, cnt_s;
  logic [2:0]  idx_r, idx_s;
  logic [7:0]  shreg_r, shreg_s;
  logic        wr_r, wr_s;
  logic [7:0]  data_r, data_s;
  logic        ferr_r, ferr_s;
  logic        tick_s;
`ifdef RXUART_PARITY_EN
  logic        par_r, par_s;
  logic        perr_r, perr_s;
`endif

  assign tick_s      = (cnt_r == 24'd0);
  assign o_wr        = wr_r;
  assign o_data      = data_r;
  assign o_frame_err = ferr_r;
`ifdef RXUART_PARITY_EN
  assign o_parity_err = perr_r;
`endif

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta_r <= 1'b1;
      ck_rx_r   <= 1'b1;
    end else begin
      rx_meta_r <= i_uart_rx;
      ck_rx_r   <= rx_meta_r;
    end
  end

  // State, counter, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= IDLE;
      cnt_r   <= 24'd0;
      idx_r   <= 3'd0;
      shreg_r <= 8'h00;
      wr_r    <= 1'b0;
      data_r  <= 8'h00;
      ferr_r  <= 1'b0;
`ifdef RXUART_PARITY_EN
      par_r   <= 1'b0;
      perr_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shreg_r <= shreg_s;
      wr_r    <= wr_s;
      data_r  <= data_s;
      ferr_r  <= ferr_s;
`ifdef RXUART_PARITY_EN
      par_r   <= par_s;
      perr_r  <= perr_s;
`endif
    end
  end

  // Next-state logic; the counter free-runs down and parks at zero.
  always_comb begin
    state_s = state_r;
    cnt_s   = tick_s ? cnt_r : (cnt_r - 24'd1);
    idx_s   = idx_r;
    shreg_s = shreg_r;
    wr_s    = 1'b0;
    data_s  = data_r;
    ferr_s  = ferr_r;
`ifdef RXUART_PARITY_EN
    par_s   = par_r;
    perr_s  = perr_r;
`endif
    case (state_r)
      IDLE: begin
        if (!ck_rx_r) begin
          cnt_s   = HALF_C;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s && ck_rx_r) begin
          state_s = IDLE;
        end else if (tick_s) begin
          cnt_s   = FULL_C;
          idx_s   = 3'd0;
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shreg_s = {ck_rx_r, shreg_r[7:1]};
          cnt_s   = FULL_C;
          idx_s   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
`ifdef RXUART_PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            state_s = DATA;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef RXUART_PARITY_EN
      PARITY: begin
        if (tick_s) begin
          par_s   = ck_rx_r;
          cnt_s   = FULL_C;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick_s) begin
          wr_s    = 1'b1;
          data_s  = shreg_r;
          ferr_s  = ~ck_rx_r;
`ifdef RXUART_PARITY_EN
          perr_s  = parity_err_f(shreg_r, par_r);
`endif
          state_s = ck_rx_r ? IDLE : BREAK;
        end else begin
          state_s = STOP;
        end
      end
      BREAK: begin
        if (ck_rx_r) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rxuart_lite.sv
// Directed self-checking bench for rxuart_lite at CLOCKS_PER_BAUD=16.
module tb_rxuart_lite;

  localparam int CPB = 16;
`ifdef RXUART_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_uart_rx = 1'b1;
  logic       o_wr;
  logic [7:0] o_data;
  logic       o_frame_err;
`ifdef RXUART_PARITY_EN
  logic       o_parity_err;
  bit         got_perr[$];
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  logic [7:0] got_data[$];
  bit         got_ferr[$];
  int         got_cyc[$];

  rxuart_lite #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_uart_rx(i_uart_rx),
    .o_wr(o_wr),
    .o_data(o_data),
`ifdef RXUART_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (o_wr === 1'b1) begin
      got_data.push_back(o_data);
      got_ferr.push_back(o_frame_err);
      got_cyc.push_back(cyc);
`ifdef RXUART_PARITY_EN
      got_perr.push_back(o_parity_err);
`endif
    end
  end

  task automatic clear_q();
    got_data.delete();
    got_ferr.delete();
    got_cyc.delete();
`ifdef RXUART_PARITY_EN
    got_perr.delete();
`endif
  endtask

  task automatic idle(input int n);
    i_uart_rx = 1'b1;
    repeat (n) @(negedge i_clk);
  endtask

  // Drives one ideal frame starting at a falling clock edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    start_cyc = cyc;
    i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int b = 0; b < 8; b++) begin
      i_uart_rx = d[b];
      repeat (CPB) @(negedge i_clk);
    end
`ifdef RXUART_PARITY_EN
    i_uart_rx = par_b;
    repeat (CPB) @(negedge i_clk);
`endif
    i_uart_rx = stop_b;
    repeat (CPB) @(negedge i_clk);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic check_one(input string name, input logic [7:0] exp_d, input bit exp_f);
    checks++;
    if (got_data.size() !== 1) begin
      errors++;
      $display("FAIL %s count: got %0d want 1", name, got_data.size());
    end else begin
      checks += 2;
      if (got_data[0] !== exp_d) begin
        errors++;
        $display("FAIL %s data: got %02h want %02h", name, got_data[0], exp_d);
      end
      if (got_ferr[0] !== exp_f) begin
        errors++;
        $display("FAIL %s frame_err: got %0b want %0b", name, got_ferr[0], exp_f);
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_wr, o_data, o_frame_err} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wr=%0b data=%02h fe=%0b want 0/00/0", o_wr, o_data, o_frame_err);
    end
    i_reset = 1'b0;
    idle(10);
  endtask

  task automatic test_single();
    clear_q();
    send_frame(8'h48, 1'b1, even_par(8'h48));
    idle(20);
    check_one("single", 8'h48, 1'b0);
    checks++;
    if (got_cyc.size() != 1 || (got_cyc[0] - start_cyc) < LAT - 1 || (got_cyc[0] - start_cyc) > LAT + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d want %0d", (got_cyc.size() > 0) ? got_cyc[0] - start_cyc : -1, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [16] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20, 8'h0A, 8'h0D};
    clear_q();
    for (int i = 0; i < 16; i++) send_frame(msg[i], 1'b1, even_par(msg[i]));
    idle(20);
    checks++;
    if (got_data.size() !== 16) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 16", got_data.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got_data[i] !== msg[i] || got_ferr[i] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_byte%0d: got %02h/fe=%0b want %02h/fe=0", i, got_data[i], got_ferr[i], msg[i]);
        end
      end
    end
  endtask

  task automatic test_glitch();
    clear_q();
    i_uart_rx = 1'b0;
    repeat (4) @(negedge i_clk);
    idle(40);
    checks++;
    if (got_data.size() !== 0) begin
      errors++;
      $display("FAIL glitch_no_wr: got %0d pulses want 0", got_data.size());
    end
    send_frame(8'h5A, 1'b1, even_par(8'h5A));
    idle(20);
    check_one("glitch_next", 8'h5A, 1'b0);
  endtask

  task automatic test_frame_err();
    clear_q();
    send_frame(8'h55, 1'b0, even_par(8'h55));
    i_uart_rx = 1'b0;
    repeat (100) @(negedge i_clk);
    check_one("frame_err", 8'h55, 1'b1);
    idle(20);
    clear_q();
    send_frame(8'h0F, 1'b1, even_par(8'h0F));
    idle(20);
    check_one("after_break", 8'h0F, 1'b0);
  endtask

  task automatic test_async_reset();
    clear_q();
    i_uart_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    i_uart_rx = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    checks++;
    if ({o_wr, o_data, o_frame_err} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got wr=%0b data=%02h fe=%0b want 0/00/0", o_wr, o_data, o_frame_err);
    end
    @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    idle(200);
    checks++;
    if (got_data.size() !== 0) begin
      errors++;
      $display("FAIL reset_no_wr: got %0d pulses want 0", got_data.size());
    end
    send_frame(8'hA5, 1'b1, even_par(8'hA5));
    idle(20);
    check_one("after_reset", 8'hA5, 1'b0);
  endtask

`ifdef RXUART_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      clear_q();
      send_frame(8'h03, 1'b1, k[0]);
      idle(20);
      check_one("parity", 8'h03, 1'b0);
      checks++;
      if (got_perr.size() != 1 || got_perr[0] !== k[0]) begin
        errors++;
        $display("FAIL parity_err%0d: got %0d want %0b", k, (got_perr.size() > 0) ? int'(got_perr[0]) : -1, k[0]);
      end
    end
  endtask
`endif

  initial begin
    @(negedge i_clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_async_reset();
`ifdef RXUART_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rxuart_lite.md
Name: rxuart_lite

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's fixed-baud UART transmitter.
- Synchronises the asynchronous serial line and samples each bit at mid-baud.
- Delivers each received byte as a one-cycle strobe with data and a framing-error flag.
- Sits at the FPGA top level, next to the transmitter, feeding a loopback/echo or message-check path.

Parameters:
- CLOCKS_PER_BAUD, 24'd868, clock cycles per baud (100 MHz / 115200). Legal range 4 to 2^24-1.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_uart_rx  input  1  serial line, idle high, asynchronous to i_clk.
- o_wr  output  1  one-cycle strobe: byte received.
- o_data  output  8  received byte; valid when o_wr=1; holds its value until the next o_wr.
- o_frame_err  output  1  qualifies o_wr: 1 when the stop bit sampled 0.

Behaviour:
- Reset (asynchronous, active-high):
  - Both synchroniser flops go to 1; state IDLE; baud counter 0; shift register 0.
  - o_wr=0, o_data=8'h00, o_frame_err=0.
- Synchroniser: 2-flop chain; the FSM sees only the second flop (ck_rx). Input-to-FSM latency is 2 cycles.
- Baud counter: 24-bit, counts down. A "sample tick" occurs on the cycle it equals 0.
- IDLE:
  - When ck_rx==0, load counter with CLOCKS_PER_BAUD/2-1 (integer divide) and go to START.
- START (on tick):
  - ck_rx==1: false start/glitch; go to IDLE; no output.
  - ck_rx==0: load CLOCKS_PER_BAUD-1, clear bit index, go to DATA.
- DATA (on each tick):
  - Shift in LSB-first: shreg <= {ck_rx, shreg[7:1]}.
  - Reload CLOCKS_PER_BAUD-1 and increment the 3-bit index.
  - After the tick with index==7, go to STOP.
- STOP (on tick):
  - Register o_data <= shreg and o_wr <= 1 for exactly one cycle.
  - ck_rx==1: o_frame_err <= 0; go to IDLE.
  - ck_rx==0: o_frame_err <= 1; go to BREAK.
- BREAK:
  - Wait until ck_rx==1, then go to IDLE.
  - A line held low never produces further o_wr.
- o_frame_err updates only together with o_wr. It is valid only while o_wr=1 and is held otherwise.
- Latency: o_wr asserts 2 + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD + 1 cycles (±1) after the falling start edge at i_uart_rx.
- Back-to-back frames:
  - The next start bit may begin immediately after the stop bit's nominal end.
  - IDLE is re-entered at mid-stop-bit, so there is no lost frame.
- Reset mid-frame: abort immediately; no o_wr for the partial byte; o_data returns to 0.
- No flow control. The consumer must accept o_wr unconditionally; there is no overrun state.

Optional Feature:
- Macro RXUART_PARITY_EN.
- Defined: frame is 8E1.
  - Adds state PARITY between DATA and STOP, sampled on its own tick.
  - Adds output port o_parity_err (1 bit, reset 0), updated together with o_wr.
  - o_parity_err = 1 when XOR(data bits, parity bit) != 0.
  - Latency grows by one baud.
- Undefined: 8N1 only; no PARITY state; no o_parity_err port.

Test Plan:
- Bench uses CLOCKS_PER_BAUD=16. A bench task drives ideal frames.
- Single byte: frame 0x48 ('H') -> exactly one o_wr pulse, o_data=8'h48, o_frame_err=0, arriving 155±1 cycles after the start edge.
- Back-to-back stream: "Hello, World! \n\r" (16 bytes, no idle gaps) -> 16 o_wr pulses, bytes in order, all o_frame_err=0.
- Glitch: line low 4 cycles, then high -> no o_wr; FSM back in IDLE; a following byte 0x5A is received correctly.
- Framing error: 0x55 with stop bit 0, line then held low 100 cycles -> one o_wr, o_data=8'h55, o_frame_err=1; no further o_wr while low. After the line returns high, byte 0x0F is received with o_frame_err=0.
- Async reset mid-frame: assert i_reset during data bit 4 of 0xFF -> o_wr/o_data/o_frame_err go to 0 without waiting for a clock; no o_wr for that frame. After release, 0xA5 is received correctly.
- RXUART_PARITY_EN: 0x03 with parity bit 0 -> o_parity_err=0; 0x03 with parity bit 1 -> o_wr, o_data=8'h03, o_parity_err=1.
